alu_serial: RTL and testbench
=============================

// Module: alu_serial
// PURPOSE
//   Multi-cycle serial ALU that executes the 3-bit ALU control code produced by the ALU decoder.
//   It processes the operands STEP bits per cycle, LSB first, under a valid/ready handshake on both sides.
//   It is used as the execute unit in the area-reduced multicycle datapath.
// PARAMETERS
//   WIDTH  32  operand/result width in bits
//   STEP   1   bits processed per RUN cycle; WIDTH % STEP must be 0; N = WIDTH/STEP
// PORTS
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   start_valid  in   1      request valid
//   start_ready  out  1      request accepted when start_valid & start_ready
//   aluctrl      in   3      010 add, 110 sub, 000 and, 001 or, 111 slt
//   a, b         in   WIDTH  operands, sampled on accept only
//   res_valid    out  1      result valid
//   res_ready    in   1      consumer accepts result when res_valid & res_ready
//   result       out  WIDTH  result, stable while res_valid=1
//   zero         out  1      (result == 0)
//   ovf          out  1      only with ALU_SERIAL_OVF_EN; see CONFIGURATION
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, start_ready=1, res_valid=0, result=0, zero=1, ovf=0; counter and carry cleared.
// - FSM IDLE -> RUN -> DONE -> IDLE. start_ready = (state==IDLE) only.
//   - IDLE: on accept, latch a, b, aluctrl; cnt=0; carry_in = 1 for 110/111, else 0; go RUN.
//   - RUN: each cycle consumes bits [cnt*STEP +: STEP]. For sub/slt, b is inverted.
//     The slice result is shifted into result MSB-side (LSB-first assembly).
//   - RUN: after the N-th RUN edge, go DONE; res_valid=1 from that edge.
//     Latency: accept at edge T0 gives res_valid at edge T0+N.
//   - DONE: hold result, zero and ovf. On res_ready=1 go IDLE (res_valid=0).
//     The next accept is possible no earlier than one cycle later. No back-to-back overlap.
// - Arithmetic:
//   - Sum bits are modulo 2^WIDTH; the final carry-out is discarded.
//   - Internal signed overflow V = carry into MSB XOR carry out of MSB.
//   - slt: result = {WIDTH-1 zeros, sign(a-b) ^ V}. The sub path is computed internally; the difference is not output.
//   - Unsupported codes (011, 100, 101): take the same N cycles; result=0, zero=1.
// - Boundaries:
//   - start_valid while not IDLE: ignored, with no side effects.
//   - res_ready asserted in IDLE or RUN: ignored.
//   - Inputs a, b and aluctrl may change freely after accept.
//   - Reset mid-RUN or mid-DONE aborts the operation immediately; the pending result is lost.
// CONFIGURATION
// - ALU_SERIAL_OVF_EN defined: port ovf exists.
//   - ovf = V for 010/110; 0 for all other codes.
//   - ovf is valid and held with res_valid.
// - ALU_SERIAL_OVF_EN undefined: port ovf is absent. V is still computed internally for slt.
// TESTING (WIDTH=32, STEP=1 unless noted)
// 1. add: a=5, b=7, aluctrl=010, accept at T0
//    -> res_valid=1 at T0+32, result=12, zero=0; start_ready=0 during T0+1..T0+32.
// 2. sub: a=3, b=3, aluctrl=110
//    -> result=0, zero=1. With OVF_EN: a=32'h8000_0000, b=1 -> result=32'h7FFF_FFFF, ovf=1.
// 3. slt: a=32'hFFFF_FFFF (-1), b=1 -> result=1.
//    a=32'h7FFF_FFFF, b=32'h8000_0000 -> result=0 (overflow case).
// 4. Logic: a=32'hF0F0_00FF, b=32'h0FF0_0F0F
//    -> and=32'h00F0_000F; or=32'hFFF0_0FFF.
//    Repeat with STEP=4 -> res_valid at T0+8.
// 5. Backpressure: hold res_ready=0 for 5 cycles after res_valid
//    -> result/zero stable, start_valid ignored.
//    res_ready=1 -> res_valid=0 next edge, start_ready=1.
// 6. Reset: rst_n=0 at T0+10 of a 32-cycle add
//    -> outputs go to reset values immediately.
//    A new request afterwards (9+1) -> result=10 after a full 32 cycles.

Source files
------------

// File: rtl/alu_serial.sv
// alu_serial: multi-cycle serial ALU (add/sub/and/or/slt), STEP bits per cycle, LSB first.
// Define ALU_SERIAL_OVF_EN to add the ovf output (signed overflow for add/sub).
module alu_serial #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       aluctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
`ifdef ALU_SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       o_dbg_state
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2:0]         r_op;
  logic [CW-1:0]      r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_res;

  logic               w_accept;
  logic               w_last;
  logic               w_inv;
  logic [STEP-1:0]    w_a_sl;
  logic [STEP-1:0]    w_b_sl;
  logic [STEP-1:0]    w_sum;
  logic [STEP-1:0]    w_slice;
  logic               w_c_msb;
  logic               w_c_out;
  logic               w_v;
  logic               w_lt;
  logic [WIDTH-1:0]   w_res_shift;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // start_ready is high only in IDLE; res_valid only in DONE, where result/zero/ovf are held.
  assign w_accept    = start_valid && (r_state == S_IDLE);
  assign w_last      = (r_cnt == LAST);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) w_next = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // sub and slt compute a + ~b + 1; the +1 enters as the initial carry.
  assign w_inv  = (r_op == OP_SUB) || (r_op == OP_SLT);
  assign w_a_sl = r_a[STEP-1:0];
  assign w_b_sl = r_b[STEP-1:0] ^ {STEP{w_inv}};

  always_comb begin
    logic v_c;
    v_c     = r_carry;
    w_sum   = '0;
    w_c_msb = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (i == STEP - 1) w_c_msb = v_c;
      w_sum[i] = w_a_sl[i] ^ w_b_sl[i] ^ v_c;
      v_c      = (w_a_sl[i] & w_b_sl[i]) | (v_c & (w_a_sl[i] ^ w_b_sl[i]));
    end
    w_c_out = v_c;
  end

  // V and the sign are only meaningful on the final slice, which holds the MSB.
  assign w_v  = w_c_msb ^ w_c_out;
  assign w_lt = w_sum[STEP-1] ^ w_v;

  always_comb begin
    w_slice = '0;
    case (r_op)
      OP_ADD, OP_SUB: w_slice = w_sum;
      OP_AND:         w_slice = r_a[STEP-1:0] & r_b[STEP-1:0];
      OP_OR:          w_slice = r_a[STEP-1:0] | r_b[STEP-1:0];
      default:        w_slice = '0;
    endcase
  end

  assign w_res_shift = (r_res >> STEP) | (WIDTH'(w_slice) << (WIDTH - STEP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_res   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_op    <= aluctrl;
      r_cnt   <= '0;
      r_carry <= (aluctrl == OP_SUB) || (aluctrl == OP_SLT);
      r_res   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> STEP;
      r_b     <= r_b >> STEP;
      r_cnt   <= r_cnt + 1'b1;
      r_carry <= w_c_out;
      if (w_last && (r_op == OP_SLT)) r_res <= WIDTH'(w_lt);
      else                            r_res <= w_res_shift;
    end
  end

  assign result = r_res;
  assign zero   = (r_res == '0);

`ifdef ALU_SERIAL_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_ovf <= 1'b0;
    else if (w_accept)                    r_ovf <= 1'b0;
    else if ((r_state == S_RUN) && w_last) r_ovf <= w_v && ((r_op == OP_ADD) || (r_op == OP_SUB));
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for alu_serial: a STEP=1 instance and a STEP=4 instance share one stimulus
// driver; sel chooses which instance receives the handshake and whose outputs are observed.
module tb_alu_serial;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        res_ready;
  logic [2:0]  aluctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic        sel;

  logic        sv32, rr32, sr32, rv32, z32;
  logic [31:0] res32;
  logic [1:0]  dbg32;
  logic        sv4, rr4, sr4, rv4, z4;
  logic [31:0] res4;
  logic [1:0]  dbg4;
`ifdef ALU_SERIAL_OVF_EN
  logic        ovf32, ovf4;
`endif

  int          n_checks;
  int          n_errors;
  logic [31:0] exp_q[$];

  assign sv32 = start_valid & ~sel;
  assign rr32 = res_ready & ~sel;
  assign sv4  = start_valid & sel;
  assign rr4  = res_ready & sel;

  alu_serial #(.WIDTH(32), .STEP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_valid(sv32), .start_ready(sr32), .aluctrl(aluctrl),
    .a(a), .b(b), .res_valid(rv32), .res_ready(rr32), .result(res32), .zero(z32),
`ifdef ALU_SERIAL_OVF_EN
    .ovf(ovf32),
`endif
    .o_dbg_state(dbg32)
  );

  alu_serial #(.WIDTH(32), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4), .aluctrl(aluctrl),
    .a(a), .b(b), .res_valid(rv4), .res_ready(rr4), .result(res4), .zero(z4),
`ifdef ALU_SERIAL_OVF_EN
    .ovf(ovf4),
`endif
    .o_dbg_state(dbg4)
  );

  logic        w_sr, w_rv, w_z;
  logic [31:0] w_res;
  logic [1:0]  w_dbg;
  assign w_sr  = sel ? sr4  : sr32;
  assign w_rv  = sel ? rv4  : rv32;
  assign w_z   = sel ? z4   : z32;
  assign w_res = sel ? res4 : res32;
  assign w_dbg = sel ? dbg4 : dbg32;
`ifdef ALU_SERIAL_OVF_EN
  logic w_ovf;
  assign w_ovf = sel ? ovf4 : ovf32;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver: one full transaction, with optional result backpressure and early res_ready
  task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic [2:0] op_c, input logic [31:0] exp_res, input logic exp_ovf,
                        input int hold, input bit rr_early);
    int          k;
    int          busy_bad;
    int          lat;
    logic [31:0] exp_r;
    lat = sel ? 8 : 32;
    exp_q.push_back(exp_res);
    @(negedge clk);
    check({tag, "_start_ready"}, 32'(w_sr), 32'd1);
    start_valid = 1'b1;
    a           = op_a;
    b           = op_b;
    aluctrl     = op_c;
    res_ready   = rr_early;
    @(negedge clk);
    start_valid = 1'b0;
    a           = $urandom;
    b           = $urandom;
    aluctrl     = 3'($urandom_range(0, 7));
    k           = 0;
    busy_bad    = 0;
    while (!w_rv && k < 200) begin
      if (w_sr) busy_bad++;
      @(negedge clk);
      k++;
    end
    exp_r = exp_q.pop_front();
    check({tag, "_latency"}, 32'(k), 32'(lat));
    check({tag, "_busy_ready"}, 32'(busy_bad), 32'd0);
    check({tag, "_done_ready"}, 32'(w_sr), 32'd0);
    check({tag, "_result"}, w_res, exp_r);
    check({tag, "_zero"}, 32'(w_z), 32'(exp_r == 32'd0));
`ifdef ALU_SERIAL_OVF_EN
    check({tag, "_ovf"}, 32'(w_ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("note: %s ovf expectation undefined", tag);
`endif
    for (int i = 0; i < hold; i++) begin
      start_valid = 1'b1;
      a           = 32'd0;
      b           = 32'd0;
      aluctrl     = 3'b110;
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(w_rv), 32'd1);
      check({tag, "_hold_result"}, w_res, exp_r);
      check({tag, "_hold_zero"}, 32'(w_z), 32'(exp_r == 32'd0));
      check({tag, "_hold_ready"}, 32'(w_sr), 32'd0);
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(negedge clk);
    res_ready   = 1'b0;
    check({tag, "_rel_valid"}, 32'(w_rv), 32'd0);
    check({tag, "_rel_ready"}, 32'(w_sr), 32'd1);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    sel         = 1'b0;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    aluctrl     = 3'b000;
    a           = 32'd0;
    b           = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_start_ready", 32'(w_sr), 32'd1);
    check("rst_res_valid", 32'(w_rv), 32'd0);
    check("rst_result", w_res, 32'd0);
    check("rst_zero", 32'(w_z), 32'd1);
    check("rst_state", 32'(w_dbg), 32'd0);
    rst_n = 1'b1;

    run_op("add_5_7",      32'd5,          32'd7,          3'b010, 32'd12,         1'b0, 0, 1'b0);
    run_op("sub_3_3",      32'd3,          32'd3,          3'b110, 32'd0,          1'b0, 0, 1'b0);
    run_op("sub_min_1",    32'h8000_0000,  32'd1,          3'b110, 32'h7FFF_FFFF,  1'b1, 0, 1'b0);
    run_op("add_wrap",     32'hFFFF_FFFF,  32'd1,          3'b010, 32'd0,          1'b0, 0, 1'b0);
    run_op("add_ovf",      32'h7FFF_FFFF,  32'd1,          3'b010, 32'h8000_0000,  1'b1, 0, 1'b0);
    run_op("slt_m1_1",     32'hFFFF_FFFF,  32'd1,          3'b111, 32'd1,          1'b0, 0, 1'b0);
    run_op("slt_max_min",  32'h7FFF_FFFF,  32'h8000_0000,  3'b111, 32'd0,          1'b0, 0, 1'b0);
    run_op("slt_min_max",  32'h8000_0000,  32'h7FFF_FFFF,  3'b111, 32'd1,          1'b0, 0, 1'b0);
    run_op("slt_eq",       32'd5,          32'd5,          3'b111, 32'd0,          1'b0, 0, 1'b0);
    run_op("and",          32'hF0F0_00FF,  32'h0FF0_0F0F,  3'b000, 32'h00F0_000F,  1'b0, 0, 1'b0);
    run_op("or",           32'hF0F0_00FF,  32'h0FF0_0F0F,  3'b001, 32'hFFF0_0FFF,  1'b0, 0, 1'b0);
    run_op("unsup_011",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  3'b011, 32'd0,          1'b0, 0, 1'b0);
    run_op("unsup_101",    32'h1234_5678,  32'h0000_0001,  3'b101, 32'd0,          1'b0, 0, 1'b0);
    run_op("bp_add",       32'h0000_1234,  32'h0000_0FFF,  3'b010, 32'h0000_2233,  1'b0, 5, 1'b0);
    run_op("early_rr_sub", 32'd10,         32'd20,         3'b110, 32'hFFFF_FFF6,  1'b0, 0, 1'b1);

    // reset in the middle of a run
    @(negedge clk);
    start_valid = 1'b1;
    a           = 32'd100;
    b           = 32'd200;
    aluctrl     = 3'b010;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_start_ready", 32'(w_sr), 32'd1);
    check("midrst_res_valid", 32'(w_rv), 32'd0);
    check("midrst_result", w_res, 32'd0);
    check("midrst_zero", 32'(w_z), 32'd1);
    check("midrst_state", 32'(w_dbg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst_add", 32'd9, 32'd1, 3'b010, 32'd10, 1'b0, 0, 1'b0);

    // STEP=4 instance
    sel = 1'b1;
    run_op("s4_and",     32'hF0F0_00FF,  32'h0FF0_0F0F,  3'b000, 32'h00F0_000F,  1'b0, 0, 1'b0);
    run_op("s4_or",      32'hF0F0_00FF,  32'h0FF0_0F0F,  3'b001, 32'hFFF0_0FFF,  1'b0, 0, 1'b0);
    run_op("s4_add",     32'h0000_FFFF,  32'h0000_0001,  3'b010, 32'h0001_0000,  1'b0, 0, 1'b0);
    run_op("s4_sub_min", 32'h8000_0000,  32'd1,          3'b110, 32'h7FFF_FFFF,  1'b1, 0, 1'b0);
    run_op("s4_slt",     32'h7FFF_FFFF,  32'h8000_0000,  3'b111, 32'd0,          1'b0, 2, 1'b0);
    run_op("s4_slt_neg", 32'hFFFF_FFFF,  32'd1,          3'b111, 32'd1,          1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
